// File: rtl/adder8_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : adder8_pkg                                                  |
// | Shared widths, stage payload types and the high-part add helper       |
// | for the adder8 stitch pipeline.                                       |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package adder8_pkg;

  localparam int LO_W  = 5;
  localparam int HI_W  = 3;
  localparam int SUM_W = LO_W + HI_W;

  // Stage 1 payload: low-partition sum, active-high carry, high operands
  typedef struct packed {
    logic [LO_W-1:0] lo_sum;
    logic            c;
    logic [HI_W-1:0] a_hi;
    logic [HI_W-1:0] b_hi;
  } s1_t;

  // Stage 2 payload: stitched full sum and carry-out of the top bit
  typedef struct packed {
    logic [SUM_W-1:0] sum;
    logic             cout;
  } s2_t;

  // High-part add kept one bit wider so the carry-out is never truncated
  function automatic logic [HI_W:0] hi_add(input logic [HI_W-1:0] a,
                                           input logic [HI_W-1:0] b,
                                           input logic            c);
    return {1'b0, a} + {1'b0, b} + {{HI_W{1'b0}}, c};
  endfunction

endpackage
`default_nettype wire

// File: rtl/adder8_pipe_reg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : adder8_pipe_reg                                             |
// | Generic valid/ready register slice; loads whenever it is empty or    |
// | its content is being taken downstream in the same cycle.             |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module adder8_pipe_reg #(
  parameter type T = logic
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid,
  output logic in_ready,
  input  T     in_data,
  output logic out_valid,
  input  logic out_ready,
  output T     out_data
);

  logic valid_q, valid_d;
  T     data_q, data_d;
  logic load;

  // Next-state: refill when empty or draining; hold payload otherwise
  always_comb begin
    load    = !valid_q || out_ready;
    valid_d = valid_q;
    data_d  = data_q;
    if (load) begin
      valid_d = in_valid;
      if (in_valid) begin
        data_d = in_data;
      end
    end
  end

  // Slice state; reset empties the slot and clears the payload
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign in_ready  = load;
  assign out_valid = valid_q;
  assign out_data  = data_q;

endmodule
`default_nettype wire

// File: rtl/adder8_stitch_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : adder8_stitch_pipe                                          |
// | Adds the 3 high operand bits to the low-partition carry, stitches    |
// | the full 8-bit sum, and counts carry-out results (saturating).       |
// | Two register slices give a 2-cycle, full-throughput pipeline.        |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module adder8_stitch_pipe
  import adder8_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [LO_W-1:0]  lo_sum,
  input  logic             lo_cout_n,
  input  logic [HI_W-1:0]  a_hi,
  input  logic [HI_W-1:0]  b_hi,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SUM_W-1:0] sum,
  output logic             cout,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] cout_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  s1_t             s1_in, s1_out;
  s2_t             s2_in, s2_out;
  logic            s1_v, s2_rdy, s2_v;
  logic [HI_W:0]   hi;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Stage 1 capture; the active-low partition carry is inverted only here
  always_comb begin
    s1_in        = '0;
    s1_in.lo_sum = lo_sum;
    s1_in.c      = ~lo_cout_n;
    s1_in.a_hi   = a_hi;
    s1_in.b_hi   = b_hi;
  end

  adder8_pipe_reg #(.T(s1_t)) u_s1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (s1_in),
    .out_valid (s1_v),
    .out_ready (s2_rdy),
    .out_data  (s1_out)
  );

  // Stage 2 compute: high add with carry, then stitch above the low bits
  always_comb begin
    hi         = hi_add(s1_out.a_hi, s1_out.b_hi, s1_out.c);
    s2_in      = '0;
    s2_in.sum  = {hi[HI_W-1:0], s1_out.lo_sum};
    s2_in.cout = hi[HI_W];
  end

  adder8_pipe_reg #(.T(s2_t)) u_s2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (s1_v),
    .in_ready  (s2_rdy),
    .in_data   (s2_in),
    .out_valid (s2_v),
    .out_ready (out_ready),
    .out_data  (s2_out)
  );

  // Carry-event counter: clear dominates, increment saturates at all-ones
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (s2_v && out_ready && s2_out.cout && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign out_valid = s2_v;
  assign sum       = s2_out.sum;
  assign cout      = s2_out.cout;
  assign cout_cnt  = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_adder8_stitch_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_adder8_stitch_pipe                                       |
// | Self-checking bench: vector table, stall stream, random traffic,     |
// | async reset and counter saturation on a narrow-counter instance.     |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_adder8_stitch_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       in_valid, in_ready, lo_cout_n, out_valid, out_ready, cout, cnt_clr;
  logic [4:0] lo_sum;
  logic [2:0] a_hi, b_hi;
  logic [7:0] sum;
  logic [15:0] cout_cnt;

  adder8_stitch_pipe #(.CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .lo_sum(lo_sum), .lo_cout_n(lo_cout_n), .a_hi(a_hi), .b_hi(b_hi),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout),
    .cnt_clr(cnt_clr), .cout_cnt(cout_cnt)
  );

  // Narrow-counter instance so saturation is reachable in a few cycles
  logic       s_in_valid, s_in_ready, s_out_valid, s_cout, s_cnt_clr;
  logic [7:0] s_sum;
  logic [1:0] s_cout_cnt;

  adder8_stitch_pipe #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .lo_sum(5'h00), .lo_cout_n(1'b0), .a_hi(3'd7), .b_hi(3'd0),
    .out_valid(s_out_valid), .out_ready(1'b1), .sum(s_sum), .cout(s_cout),
    .cnt_clr(s_cnt_clr), .cout_cnt(s_cout_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [8:0] exp_q[$];
  int         cnt_m = 0;
  logic       held_v = 1'b0;
  logic [7:0] held_sum;
  logic       held_cout;
  logic       took, rdy;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] s;
    logic       c;
  } vec_t;
  vec_t vecs[8];

  logic [7:0] sa[9];
  logic [7:0] sb[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock of main-DUT traffic; entered and left at posedge+1
  task automatic step(input logic iv, input logic [7:0] a, input logic [7:0] b,
                      input logic ordy, input logic clr,
                      output logic tk, output logic rd);
    logic [5:0] lo;
    logic [8:0] e;
    logic       xo;
    lo        = {1'b0, a[4:0]} + {1'b0, b[4:0]};
    in_valid  = iv;
    lo_sum    = lo[4:0];
    lo_cout_n = ~lo[5];
    a_hi      = a[7:5];
    b_hi      = b[7:5];
    out_ready = ordy;
    cnt_clr   = clr;
    #2;
    if (held_v) begin
      check("stall_valid", out_valid, 1);
      check("stall_sum", sum, held_sum);
      check("stall_cout", cout, held_cout);
    end
    held_v    = out_valid && !out_ready;
    held_sum  = sum;
    held_cout = cout;
    xo = out_valid && out_ready;
    rd = in_ready;
    tk = iv && in_ready;
    e  = '0;
    if (xo) begin
      if (exp_q.size() == 0) begin
        check("spurious_out", exp_q.size(), 1);
      end else begin
        e = exp_q.pop_front();
        check("sum", sum, e[7:0]);
        check("cout", cout, e[8]);
      end
    end
    if (tk) exp_q.push_back({1'b0, a} + {1'b0, b});
    if (clr) cnt_m = 0;
    else if (xo && e[8] && cnt_m < 65535) cnt_m++;
    @(posedge clk);
    #1;
    check("cout_cnt", cout_cnt, cnt_m);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) step(1'b0, 8'h0, 8'h0, 1'b1, 1'b0, took, rdy);
    check("drain_empty", exp_q.size(), 0);
  endtask

  // One clock of saturation-instance traffic with its own counter model
  int s_cnt_m = 0;
  task automatic sat_cycle(input logic iv, input logic clr, output logic xo);
    s_in_valid = iv;
    s_cnt_clr  = clr;
    #2;
    xo = s_out_valid && s_cout;
    if (clr) s_cnt_m = 0;
    else if (xo && s_cnt_m < 3) s_cnt_m++;
    @(posedge clk);
    #1;
    check("sat_cnt", s_cout_cnt, s_cnt_m);
  endtask

  initial begin
    logic xo;
    int   idx;

    vecs[0] = '{8'h25, 8'h13, 8'h38, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 8'h00, 1'b1};
    vecs[2] = '{8'h00, 8'h00, 8'h00, 1'b0};
    vecs[3] = '{8'hFF, 8'hFF, 8'hFE, 1'b1};
    vecs[4] = '{8'h1F, 8'h01, 8'h20, 1'b0};
    vecs[5] = '{8'h80, 8'h80, 8'h00, 1'b1};
    vecs[6] = '{8'hE0, 8'h1F, 8'hFF, 1'b0};
    vecs[7] = '{8'h7F, 8'h81, 8'h00, 1'b1};

    s_in_valid = 1'b0;
    s_cnt_clr  = 1'b0;

    // Reset held low with in_valid asserted
    rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b1; cnt_clr = 1'b0;
    lo_sum = 5'h1F; lo_cout_n = 1'b0; a_hi = 3'd5; b_hi = 3'd6;
    repeat (3) begin
      @(posedge clk); #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_in_ready", in_ready, 1);
      check("rst_cout_cnt", cout_cnt, 0);
      check("rst_sum", sum, 0);
      check("rst_cout", cout, 0);
    end
    rst_n = 1'b1;

    // Vector table, one item at a time to observe the 2-cycle latency
    for (int i = 0; i < 8; i++) begin
      step(1'b1, vecs[i].a, vecs[i].b, 1'b1, 1'b0, took, rdy);
      check("tbl_taken", took, 1);
      check("tbl_lat1_valid", out_valid, 0);
      step(1'b0, 8'h0, 8'h0, 1'b1, 1'b0, took, rdy);
      check("tbl_lat2_valid", out_valid, 1);
      check("tbl_sum", sum, vecs[i].s);
      check("tbl_cout", cout, vecs[i].c);
      step(1'b0, 8'h0, 8'h0, 1'b1, 1'b0, took, rdy);
    end
    check("tbl_cnt", cout_cnt, 4);

    // Back-to-back stream of 8 with downstream stalled in cycles 3-6
    for (int i = 0; i < 9; i++) begin
      sa[i] = 8'($urandom);
      sb[i] = 8'($urandom);
    end
    idx = 0;
    for (int cyc = 1; cyc <= 40 && (idx < 8 || exp_q.size() > 0); cyc++) begin
      step(idx < 8, sa[idx], sb[idx], !(cyc >= 3 && cyc <= 6), 1'b0, took, rdy);
      if (cyc >= 3 && cyc <= 6) check("bb_in_ready_low", rdy, 0);
      if (took) idx++;
    end
    check("bb_all_sent", idx, 8);
    check("bb_drained", exp_q.size(), 0);

    // Random traffic with random backpressure and occasional clears
    for (int i = 0; i < 300; i++) begin
      step($urandom_range(0, 3) != 0, 8'($urandom), 8'($urandom),
           $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0, took, rdy);
    end
    drain();

    // Fill both stages, then pulse reset asynchronously mid-cycle
    step(1'b1, 8'hF0, 8'h20, 1'b0, 1'b0, took, rdy);
    step(1'b1, 8'hAA, 8'h55, 1'b0, 1'b0, took, rdy);
    check("ar_full_valid", out_valid, 1);
    check("ar_full_in_ready", in_ready, 0);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_out_valid", out_valid, 0);
    check("ar_in_ready", in_ready, 1);
    check("ar_cout_cnt", cout_cnt, 0);
    exp_q.delete();
    cnt_m  = 0;
    held_v = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    step(1'b0, 8'h0, 8'h0, 1'b1, 1'b0, took, rdy);
    check("ar_no_ghost", out_valid, 0);
    step(1'b1, 8'hC3, 8'h4E, 1'b1, 1'b0, took, rdy);
    check("ar_lat1_valid", out_valid, 0);
    step(1'b0, 8'h0, 8'h0, 1'b1, 1'b0, took, rdy);
    check("ar_lat2_valid", out_valid, 1);
    check("ar_sum", sum, 8'h11);
    check("ar_cout", cout, 1);
    drain();

    // Counter saturation on the 2-bit instance (max 3)
    sat_cycle(1'b1, 1'b0, xo);
    sat_cycle(1'b1, 1'b0, xo);
    sat_cycle(1'b0, 1'b0, xo);
    sat_cycle(1'b0, 1'b0, xo);
    check("sat_preload", s_cout_cnt, 2);
    for (int i = 0; i < 3; i++) sat_cycle(1'b1, 1'b0, xo);
    sat_cycle(1'b0, 1'b0, xo);
    sat_cycle(1'b0, 1'b0, xo);
    check("sat_stop", s_cout_cnt, 3);
    sat_cycle(1'b1, 1'b0, xo);
    sat_cycle(1'b1, 1'b0, xo);
    sat_cycle(1'b0, 1'b1, xo);
    check("sat_clr_xfer", xo, 1);
    check("sat_clr_wins", s_cout_cnt, 0);
    sat_cycle(1'b0, 1'b0, xo);
    check("sat_after_clr", s_cout_cnt, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
